fg_config_loader: RTL and testbench
===================================

Name: fg_config_loader

Overview:
Byte-stream configuration front end for the function generator. It receives framed bytes from a host link (UART/SPI byte adapter) over a valid/ready handshake and assembles them in a shadow register. After checksum validation it commits the word atomically onto the generator's CR_bus and drives the generator's output-enable. It is the writer side of the CR_bus/outputEnable interface that the function generator consumes.

Parameters:
CONFIG_REG_BITWIDTH, 64, width of CR_bus_o; must be a multiple of 8; NBYTES = CONFIG_REG_BITWIDTH/8.
TIMEOUT_CYCLES, 1000, maximum idle clocks between bytes inside a frame; 0 disables the timeout.
RESET_CONFIG, all zeros, value of CR_bus_o after reset.

Ports:
clk_i  in  1  system clock, all logic on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
byte_i  in  8  incoming frame byte.
byteValid_i  in  1  byte_i is valid.
byteReady_o  out  1  loader accepts byte_i; a transfer occurs when byteValid_i && byteReady_o at a rising edge.
CR_bus_o  out  CONFIG_REG_BITWIDTH  committed configuration word to the generator.
outputEnable_o  out  1  generator output enable.
configUpdate_STRB_o  out  1  one-cycle pulse in the first cycle CR_bus_o holds a newly committed value.
frameError_STRB_o  out  1  one-cycle pulse on a discarded frame.
busy_o  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (async, rst_i=1):
  - Outputs: CR_bus_o=RESET_CONFIG, outputEnable_o=0, both strobes 0, busy_o=0, byteReady_o=0.
  - Internal: state=IDLE, shadow register, byte index and timeout counter cleared.
  - Reset asserted mid-frame discards the frame with no strobe.
- byteReady_o = !rst_i && (state != COMMIT).
- Commands, as the first byte of a frame in IDLE:
  - 0xA5: write config. Go to DATA, index=0.
  - 0x5A: next cycle outputEnable_o=1. Stay IDLE.
  - 0x3C: next cycle outputEnable_o=0. Stay IDLE.
  - Any other value: frameError_STRB_o pulses the next cycle. Stay IDLE.
- DATA state:
  - NBYTES bytes, MSB byte first; each accepted byte is shifted into the shadow register.
  - A running XOR of the accepted data bytes is kept.
  - After byte NBYTES-1 is accepted, go to CHECK.
- CHECK state:
  - One byte is accepted.
  - If it equals the running XOR, go to COMMIT.
  - Otherwise, next cycle frameError_STRB_o=1 and go to IDLE; CR_bus_o is unchanged.
- COMMIT state:
  - Lasts exactly 1 cycle with byteReady_o=0.
  - On exiting COMMIT, CR_bus_o takes the shadow value and configUpdate_STRB_o=1 for that cycle; then IDLE.
  - Latency: checksum byte accepted at edge N, CR_bus_o updated and strobe high from edge N+1, next byte accepted no earlier than edge N+2.
- CR_bus_o changes only on commit; a partial or failed frame never alters it.
- outputEnable_o is unaffected by config writes.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter is cleared on every accepted byte and increments each clock in DATA or CHECK without a transfer.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, frameError_STRB_o pulses for 1 cycle, shadow register is discarded.
  - If the timeout edge coincides with a byte transfer, the transfer wins and the counter clears.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Strobes are registered, never combinational, and never high for two consecutive cycles from one event.
- byteValid_i is ignored while byteReady_o=0; a held byte is accepted on the first ready cycle.
- busy_o is high in DATA, CHECK and COMMIT.

Test Plan:
- Reset values: assert rst_i mid-clock -> immediately CR_bus_o=0, outputEnable_o=0, byteReady_o=0, strobes 0.
- Good write: bytes A5,80,00,00,00,00,00,00,12, checksum 92 -> CR_bus_o=64'h8000000000000012 one edge after the checksum; configUpdate_STRB_o high exactly 1 cycle; byteReady_o low that cycle.
- Bad checksum: same frame with checksum 93 -> frameError_STRB_o 1 cycle; CR_bus_o keeps its previous value; no update strobe; busy_o=0 afterwards.
- Enable/disable: byte 5A -> outputEnable_o=1; then 3C -> 0; unknown byte 77 -> error pulse, enable unchanged.
- Timeout (TIMEOUT_CYCLES=10): A5,11,22 then byteValid_i=0 for 10 clocks -> error pulse, state IDLE; a following full valid frame commits correctly.
- Backpressure/back-to-back: two consecutive valid frames with byteValid_i held high continuously -> exactly one stall cycle per frame (COMMIT), two update strobes, final CR_bus_o equals the second frame.

Source files
------------

// File: rtl/fg_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fg_config_loader
//  Description : Byte-stream configuration front end for the function
//                generator. Assembles framed bytes into a shadow register,
//                validates an XOR checksum and commits the word atomically
//                onto CR_bus_o. Also drives the generator output enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module fg_config_loader #(
  parameter int                             CONFIG_REG_BITWIDTH = 64,
  parameter int                             TIMEOUT_CYCLES      = 1000,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_CONFIG        = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [7:0]                     byte_i,
  input  logic                           byteValid_i,
  output logic                           byteReady_o,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           outputEnable_o,
  output logic                           configUpdate_STRB_o,
  output logic                           frameError_STRB_o,
  output logic                           busy_o
);

  localparam int W      = CONFIG_REG_BITWIDTH;
  localparam int NBYTES = W / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE   = 8'hA5;
  localparam logic [7:0] CMD_ENABLE  = 8'h5A;
  localparam logic [7:0] CMD_DISABLE = 8'h3C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   shadow_q;
  logic [W-1:0]   cr_q;
  logic [IW-1:0]  idx_q;
  logic [7:0]     xor_q;
  logic [TW-1:0]  tmo_q;
  logic           oe_q;
  logic           upd_q;
  logic           err_q;

  logic           xfer_d;
  logic           tmo_hit_d;

  // Handshake: ready everywhere except the single COMMIT cycle and reset.
  always_comb begin
    byteReady_o = !rst_i && (state_q != COMMIT);
    xfer_d      = byteValid_i && byteReady_o;
    tmo_hit_d   = TMO_EN && (tmo_q >= TMO_LAST);
  end

  // Frame FSM with shadow assembly, checksum, inter-byte timeout and commit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cr_q     <= RESET_CONFIG;
      idx_q    <= '0;
      xor_q    <= '0;
      tmo_q    <= '0;
      oe_q     <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (xfer_d) begin
            case (byte_i)
              CMD_WRITE: begin
                state_q  <= DATA;
                idx_q    <= '0;
                xor_q    <= '0;
                shadow_q <= '0;
              end
              CMD_ENABLE:  oe_q  <= 1'b1;
              CMD_DISABLE: oe_q  <= 1'b0;
              default:     err_q <= 1'b1;
            endcase
          end
        end

        DATA, CHECK: begin
          if (xfer_d) begin
            // A transfer always wins over a coincident timeout.
            tmo_q <= '0;
            if (state_q == DATA) begin
              shadow_q <= (shadow_q << 8) | W'(byte_i);
              xor_q    <= xor_q ^ byte_i;
              if (idx_q == LAST_IDX) begin
                state_q <= CHECK;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else if (byte_i == xor_q) begin
              state_q <= COMMIT;
            end else begin
              state_q  <= IDLE;
              err_q    <= 1'b1;
              shadow_q <= '0;
            end
          end else if (tmo_hit_d) begin
            state_q  <= IDLE;
            err_q    <= 1'b1;
            shadow_q <= '0;
            tmo_q    <= '0;
          end else if (TMO_EN && (tmo_q != TMO_LIMIT)) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        COMMIT: begin
          cr_q    <= shadow_q;
          upd_q   <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered outputs straight from state.
  always_comb begin
    CR_bus_o            = cr_q;
    outputEnable_o      = oe_q;
    configUpdate_STRB_o = upd_q;
    frameError_STRB_o   = err_q;
    busy_o              = (state_q != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_fg_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fg_config_loader
//  Description : Directed self-checking bench for fg_config_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fg_config_loader;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        byteValid_i;
  logic        byteReady_o;
  logic [63:0] CR_bus_o;
  logic        outputEnable_o;
  logic        configUpdate_STRB_o;
  logic        frameError_STRB_o;
  logic        busy_o;

  int tests;
  int fails;

  fg_config_loader #(
    .CONFIG_REG_BITWIDTH(64),
    .TIMEOUT_CYCLES     (10),
    .RESET_CONFIG       (64'h0)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .byte_i             (byte_i),
    .byteValid_i        (byteValid_i),
    .byteReady_o        (byteReady_o),
    .CR_bus_o           (CR_bus_o),
    .outputEnable_o     (outputEnable_o),
    .configUpdate_STRB_o(configUpdate_STRB_o),
    .frameError_STRB_o  (frameError_STRB_o),
    .busy_o             (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one byte and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    byteValid_i = 1'b1;
    byte_i      = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = byteReady_o;
      step();
    end
    byteValid_i = 1'b0;
    if (!acc) chk("send_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [63:0] w, input logic [7:0] cs);
    send(8'hA5);
    for (int i = 7; i >= 0; i--) send(w[i*8 +: 8]);
    send(cs);
  endtask

  logic [7:0] stream [21];
  int         idx;
  int         stalls;
  int         upds;
  logic       rdy;

  initial begin
    tests = 0;
    fails = 0;
    rst_i = 1'b1;
    byteValid_i = 1'b0;
    byte_i = 8'h00;

    // Reset state
    #3;
    chk("rst_cr", CR_bus_o, 64'h0);
    chk("rst_oe", {63'b0, outputEnable_o}, 64'd0);
    chk("rst_ready", {63'b0, byteReady_o}, 64'd0);
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_upd", {63'b0, configUpdate_STRB_o}, 64'd0);
    chk("rst_err", {63'b0, frameError_STRB_o}, 64'd0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", {63'b0, byteReady_o}, 64'd1);

    // Good write: checksum 0x92
    send(8'hA5);
    chk("busy_in_data", {63'b0, busy_o}, 64'd1);
    send(8'h80);
    for (int i = 0; i < 6; i++) send(8'h00);
    send(8'h12);
    send(8'h92);
    chk("commit_ready_low", {63'b0, byteReady_o}, 64'd0);
    chk("commit_cr_not_yet", CR_bus_o, 64'h0);
    step();
    chk("good_cr", CR_bus_o, 64'h8000000000000012);
    chk("good_upd_high", {63'b0, configUpdate_STRB_o}, 64'd1);
    chk("good_ready_back", {63'b0, byteReady_o}, 64'd1);
    step();
    chk("good_upd_one_cycle", {63'b0, configUpdate_STRB_o}, 64'd0);
    chk("good_busy_idle", {63'b0, busy_o}, 64'd0);

    // Bad checksum
    send_frame(64'h8000000000000012, 8'h93);
    chk("bad_err_high", {63'b0, frameError_STRB_o}, 64'd1);
    chk("bad_cr_kept", CR_bus_o, 64'h8000000000000012);
    chk("bad_no_upd", {63'b0, configUpdate_STRB_o}, 64'd0);
    chk("bad_busy_idle", {63'b0, busy_o}, 64'd0);
    step();
    chk("bad_err_one_cycle", {63'b0, frameError_STRB_o}, 64'd0);
    chk("bad_cr_still", CR_bus_o, 64'h8000000000000012);

    // Enable / disable / unknown command
    send(8'h5A);
    chk("oe_on", {63'b0, outputEnable_o}, 64'd1);
    send(8'h3C);
    chk("oe_off", {63'b0, outputEnable_o}, 64'd0);
    send(8'h5A);
    chk("oe_on2", {63'b0, outputEnable_o}, 64'd1);
    send(8'h77);
    chk("unk_err", {63'b0, frameError_STRB_o}, 64'd1);
    chk("unk_oe_kept", {63'b0, outputEnable_o}, 64'd1);
    chk("unk_busy", {63'b0, busy_o}, 64'd0);
    step();
    chk("unk_err_one_cycle", {63'b0, frameError_STRB_o}, 64'd0);

    // Timeout after 10 idle clocks
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    for (int i = 0; i < 9; i++) step();
    chk("tmo_not_yet_busy", {63'b0, busy_o}, 64'd1);
    chk("tmo_not_yet_err", {63'b0, frameError_STRB_o}, 64'd0);
    step();
    chk("tmo_err", {63'b0, frameError_STRB_o}, 64'd1);
    chk("tmo_idle", {63'b0, busy_o}, 64'd0);
    chk("tmo_cr_kept", CR_bus_o, 64'h8000000000000012);
    step();
    chk("tmo_err_one_cycle", {63'b0, frameError_STRB_o}, 64'd0);
    send_frame(64'h0102030405060708, 8'h08);
    step();
    chk("after_tmo_cr", CR_bus_o, 64'h0102030405060708);

    // Back-to-back frames with valid held high, then a trailing disable
    stream = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88,
               8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h22,
               8'h3C};
    idx = 0;
    stalls = 0;
    upds = 0;
    byteValid_i = 1'b1;
    for (int c = 0; c < 60 && idx < 21; c++) begin
      byte_i = stream[idx];
      rdy = byteReady_o;
      step();
      if (rdy) idx++;
      else stalls++;
      if (configUpdate_STRB_o) upds++;
    end
    byteValid_i = 1'b0;
    step();
    if (configUpdate_STRB_o) upds++;
    chk("b2b_all_sent", 64'(idx), 64'd21);
    chk("b2b_stalls", 64'(stalls), 64'd2);
    chk("b2b_upds", 64'(upds), 64'd2);
    chk("b2b_cr", CR_bus_o, 64'hDEADBEEF01234567);
    chk("b2b_oe_off", {63'b0, outputEnable_o}, 64'd0);

    // Asynchronous reset mid-clock, mid-frame
    send(8'h5A);
    send(8'hA5);
    send(8'h99);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_cr", CR_bus_o, 64'h0);
    chk("arst_oe", {63'b0, outputEnable_o}, 64'd0);
    chk("arst_ready", {63'b0, byteReady_o}, 64'd0);
    chk("arst_busy", {63'b0, busy_o}, 64'd0);
    chk("arst_err", {63'b0, frameError_STRB_o}, 64'd0);
    step();
    rst_i = 1'b0;
    step();
    chk("arst_no_err_after", {63'b0, frameError_STRB_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
